// File: rtl/reg_fifo.sv
// reg_fifo: register-based synchronous FIFO with registered read data,
// occupancy count, full/empty flags and per-direction ack/err pulses.
// Control is a small registered state machine; the ack/err pulses are
// decoded from its state plus a tag bit that records when both
// directions were requested on the same edge.
module reg_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [AW:0]           count,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        NO_OP    = 3'd1,
        WRITE    = 3'd2,
        WR_ERROR = 3'd3,
        READ     = 3'd4,
        RD_ERROR = 3'd5
    } state_t;

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

    state_t                state_r;
    logic                  pair_ack_r;  // READ state also accepted a write
    logic                  pair_err_r;  // accepted op came with a rejected opposite request
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]         wp_r;
    logic [AW-1:0]         rp_r;
    logic [AW:0]           count_r;
    logic [DATA_WIDTH-1:0] dout_r;

    logic full_s;
    logic empty_s;
    logic wr_acc_s;
    logic rd_acc_s;
    logic wr_rej_s;
    logic rd_rej_s;

    assign full_s  = (count_r == CNT_DEPTH);
    assign empty_s = (count_r == {(AW + 1){1'b0}});

    // Accept/reject decisions; nothing is acted on during the INIT edge.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        wr_rej_s = 1'b0;
        rd_rej_s = 1'b0;
        if (state_r != INIT) begin
            wr_acc_s = wr_en & ~full_s;
            rd_acc_s = rd_en & ~empty_s;
            wr_rej_s = wr_en & full_s;
            rd_rej_s = rd_en & empty_s;
        end else begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
            wr_rej_s = 1'b0;
            rd_rej_s = 1'b0;
        end
    end

    // Control state machine: one state per edge naming the accepted (or rejected) operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= INIT;
            pair_ack_r <= 1'b0;
            pair_err_r <= 1'b0;
        end else begin
            case (state_r)
                INIT: begin
                    state_r    <= NO_OP;
                    pair_ack_r <= 1'b0;
                    pair_err_r <= 1'b0;
                end
                default: begin
                    if (rd_acc_s) begin
                        state_r    <= READ;
                        pair_ack_r <= wr_acc_s;
                        pair_err_r <= wr_rej_s;
                    end else if (wr_acc_s) begin
                        state_r    <= WRITE;
                        pair_ack_r <= 1'b0;
                        pair_err_r <= rd_rej_s;
                    end else if (wr_rej_s) begin
                        state_r    <= WR_ERROR;
                        pair_ack_r <= 1'b0;
                        pair_err_r <= 1'b0;
                    end else if (rd_rej_s) begin
                        state_r    <= RD_ERROR;
                        pair_ack_r <= 1'b0;
                        pair_err_r <= 1'b0;
                    end else begin
                        state_r    <= NO_OP;
                        pair_ack_r <= 1'b0;
                        pair_err_r <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage, pointers, occupancy count and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wp_r    <= {AW{1'b0}};
            rp_r    <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
            dout_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            if (wr_acc_s) begin
                mem_r[wp_r] <= din;
                wp_r        <= wp_r + PTR_ONE;
            end else begin
                wp_r <= wp_r;
            end
            if (rd_acc_s) begin
                dout_r <= mem_r[rp_r];
                rp_r   <= rp_r + PTR_ONE;
            end else begin
                dout_r <= dout_r;
                rp_r   <= rp_r;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Status and handshake outputs, all derived from registered state.
    always_comb begin
        dout   = dout_r;
        count  = count_r;
        full   = full_s;
        empty  = empty_s;
        wr_ack = (state_r == WRITE) | ((state_r == READ) & pair_ack_r);
        wr_err = (state_r == WR_ERROR) | ((state_r == READ) & pair_err_r);
        rd_ack = (state_r == READ);
        rd_err = (state_r == RD_ERROR) | ((state_r == WRITE) & pair_err_r);
    end

endmodule

// File: tb/tb_reg_fifo.sv
// tb_reg_fifo: directed plus randomized stimulus for reg_fifo. The driver
// steps a queue-based FIFO model and pushes the expected post-edge view
// into a scoreboard; an independent monitor pops and compares after each
// rising edge.
module tb_reg_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef struct {
        logic [DW-1:0] dout;
        logic [AW:0]   count;
        logic          full;
        logic          empty;
        logic          wr_ack;
        logic          wr_err;
        logic          rd_ack;
        logic          rd_err;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    reg_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en),
        .din    (din),
        .rd_en  (rd_en),
        .dout   (dout),
        .full   (full),
        .empty  (empty),
        .count  (count),
        .wr_ack (wr_ack),
        .wr_err (wr_err),
        .rd_ack (rd_ack),
        .rd_err (rd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_fail = 0;
    exp_t sb_q[$];

    // Behavioural model: a plain queue of stored words.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_dout = '0;
    bit            model_init = 1'b1;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
        exp_t e;
        bit   wa;
        bit   ra;
        @(negedge clk);
        reset = r;
        wr_en = w;
        rd_en = rd;
        din   = d;
        e.wr_ack = 1'b0;
        e.wr_err = 1'b0;
        e.rd_ack = 1'b0;
        e.rd_err = 1'b0;
        if (r) begin
            model_q.delete();
            model_dout = '0;
            model_init = 1'b1;
        end else if (model_init) begin
            model_init = 1'b0;
        end else begin
            wa = w && (model_q.size() < DEPTH);
            ra = rd && (model_q.size() > 0);
            if (ra) model_dout = model_q.pop_front();
            if (wa) model_q.push_back(d);
            e.wr_ack = wa;
            e.wr_err = w && !wa;
            e.rd_ack = ra;
            e.rd_err = rd && !ra;
        end
        e.dout  = model_dout;
        e.count = (AW + 1)'(model_q.size());
        e.full  = (model_q.size() == DEPTH);
        e.empty = (model_q.size() == 0);
        sb_q.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest expectation after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("count",  DW'(count),  DW'(e.count));
                chk("full",   DW'(full),   DW'(e.full));
                chk("empty",  DW'(empty),  DW'(e.empty));
                chk("wr_ack", DW'(wr_ack), DW'(e.wr_ack));
                chk("wr_err", DW'(wr_err), DW'(e.wr_err));
                chk("rd_ack", DW'(rd_ack), DW'(e.rd_ack));
                chk("rd_err", DW'(rd_err), DW'(e.rd_err));
                chk("dout",   dout,        e.dout);
            end
        end
    end

    initial begin
        int wpct;
        int rpct;
        reset = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;

        // Reset, then the INIT edge.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Fill with 0x11..0x88, then one write too many.
        for (int k = 1; k <= 8; k++) cycle(1'b0, 1'b1, 1'b0, DW'(k * 32'h11));
        cycle(1'b0, 1'b1, 1'b0, 32'h99);
        // Drain in order, then one read too many.
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Pointer wrap.
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, DW'(32'h50 + k));
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b0, 1'b1, 32'h0);
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1, 1'b0, DW'(32'hA0 + k));
        for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 1'b1, 32'h0);

        // Simultaneous requests at empty, mid-level and full.
        cycle(1'b0, 1'b1, 1'b1, 32'hC0);
        cycle(1'b0, 1'b1, 1'b0, 32'hC1);
        cycle(1'b0, 1'b1, 1'b0, 32'hC2);
        cycle(1'b0, 1'b1, 1'b1, 32'hC3);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, DW'(32'hD0 + k));
        cycle(1'b0, 1'b1, 1'b1, 32'hEE);

        // Reset with data stored and a concurrent write, then a read.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0, DW'(32'hF0 + k));
        cycle(1'b1, 1'b1, 1'b0, 32'hFF);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0);

        // Randomized traffic with shifting write/read bias and rare resets.
        for (int blk = 0; blk < 20; blk++) begin
            wpct = $urandom_range(10, 90);
            rpct = $urandom_range(10, 90);
            for (int k = 0; k < 100; k++) begin
                cycle($urandom_range(0, 199) == 0,
                      $urandom_range(0, 99) < wpct,
                      $urandom_range(0, 99) < rpct,
                      $urandom);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Let the monitor drain the scoreboard, with a bound.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
